// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline memory stage, EX/MEM -> MEM/WB, with a multi-cycle
// load/store against an internal 64-bit word array.
//   Clk, Rst_n            clock, asynchronous active-low reset
//   IValid, IFlush        upstream instruction valid, synchronous kill
//   IMemRead, IMemWrite   load / store request (store wins when both set)
//   IWB, IAlu             write-back control, ALU result / byte address
//   IWriteData            store data
//   IInstruction          destination register index
//   OStall                upstream must hold its inputs while high
//   OValid, OWB           result valid for MEM/WB, write-back control
//   ODataMemory           load data (0 for non-loads and misaligned ops)
//   OAlu, OInstruction    passed-through ALU result and destination
//   OMisaligned           one-cycle flag alongside OValid for misaligned ops
module mem_access_stage #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int LAT    = 2
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        IValid,
    input  logic        IFlush,
    input  logic        IMemRead,
    input  logic        IMemWrite,
    input  logic [1:0]  IWB,
    input  logic [63:0] IAlu,
    input  logic [63:0] IWriteData,
    input  logic [4:0]  IInstruction,
    output logic        OStall,
    output logic        OValid,
    output logic [1:0]  OWB,
    output logic [63:0] ODataMemory,
    output logic [63:0] OAlu,
    output logic [4:0]  OInstruction,
    output logic        OMisaligned
);
    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              accept, pass, done, aligned;
    logic              c_rd, c_wr;
    logic [1:0]        c_wb;
    logic [63:0]       c_alu, c_wdata;
    logic [4:0]        c_instr;
    logic [ADDR_W-1:0] idx;
    logic [63:0]       mem [DEPTH];

    assign OStall  = (state == BUSY);
    assign pass    = (state == IDLE) && !IFlush && IValid && !(IMemRead || IMemWrite);
    assign accept  = (state == IDLE) && !IFlush && IValid && (IMemRead || IMemWrite);
    assign idx     = c_alu[ADDR_W+2:3];
    assign aligned = (c_alu[2:0] == 3'b000);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done      = 1'b0;
        if (accept) begin
            state_nxt = BUSY;
            cnt_nxt   = CNT_W'(LAT - 1);
        end else if (state == BUSY) begin
            if (IFlush) begin
                state_nxt = IDLE;
            end else if (cnt != '0) begin
                cnt_nxt = cnt - CNT_W'(1);
            end else begin
                state_nxt = IDLE;
                done      = 1'b1;
            end
        end
    end

    // Array is intentionally not reset; reset forces IDLE so done cannot fire.
    always_ff @(posedge Clk) begin
        if (done && aligned && c_wr)
            mem[idx] <= c_wdata;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            OValid       <= 1'b0;
            OWB          <= '0;
            ODataMemory  <= '0;
            OAlu         <= '0;
            OInstruction <= '0;
            OMisaligned  <= 1'b0;
            c_rd         <= 1'b0;
            c_wr         <= 1'b0;
            c_wb         <= '0;
            c_alu        <= '0;
            c_wdata      <= '0;
            c_instr      <= '0;
        end else begin
            OValid      <= 1'b0;
            OWB         <= '0;
            OMisaligned <= 1'b0;
            if (pass) begin
                OValid       <= 1'b1;
                OWB          <= IWB;
                OAlu         <= IAlu;
                OInstruction <= IInstruction;
                ODataMemory  <= '0;
            end
            if (accept) begin
                c_rd    <= IMemRead;
                c_wr    <= IMemWrite;
                c_wb    <= IWB;
                c_alu   <= IAlu;
                c_wdata <= IWriteData;
                c_instr <= IInstruction;
            end
            // Read sees the pre-write word when load and store coincide.
            if (done) begin
                OValid       <= 1'b1;
                OAlu         <= c_alu;
                OInstruction <= c_instr;
                OWB          <= aligned ? c_wb : 2'b00;
                OMisaligned  <= !aligned;
                ODataMemory  <= (aligned && c_rd) ? mem[idx] : 64'd0;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed self-checking bench for mem_access_stage.
module tb_mem_access_stage;
    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        IValid, IFlush, IMemRead, IMemWrite;
    logic [1:0]  IWB;
    logic [63:0] IAlu, IWriteData;
    logic [4:0]  IInstruction;
    logic        OStall, OValid, OMisaligned;
    logic [1:0]  OWB;
    logic [63:0] ODataMemory, OAlu;
    logic [4:0]  OInstruction;
    int          checks = 0;
    int          failures = 0;

    mem_access_stage #(.DEPTH(256), .ADDR_W(8), .LAT(2)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .IValid(IValid), .IFlush(IFlush),
        .IMemRead(IMemRead), .IMemWrite(IMemWrite), .IWB(IWB), .IAlu(IAlu),
        .IWriteData(IWriteData), .IInstruction(IInstruction), .OStall(OStall),
        .OValid(OValid), .OWB(OWB), .ODataMemory(ODataMemory), .OAlu(OAlu),
        .OInstruction(OInstruction), .OMisaligned(OMisaligned)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic idle_in();
        IValid = 0; IFlush = 0; IMemRead = 0; IMemWrite = 0;
        IWB = 0; IAlu = 0; IWriteData = 0; IInstruction = 0;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [63:0] alu,
                         input logic [63:0] wd, input logic [4:0] rdst, input logic [1:0] wb);
        IValid = 1; IMemRead = rd; IMemWrite = wr; IAlu = alu;
        IWriteData = wd; IInstruction = rdst; IWB = wb;
    endtask

    // Issue a memory op, hold it while stalled, and leave outputs at the result.
    task automatic mem_op(input string tag, input logic rd, input logic wr, input logic [63:0] alu,
                          input logic [63:0] wd, input logic [4:0] rdst, input logic [1:0] wb);
        int n;
        drive(rd, wr, alu, wd, rdst, wb);
        step();
        n = 0;
        while (OStall && n < 10) begin
            n++;
            step();
        end
        check({tag, "_stall_cycles"}, 64'(n), 64'd2);
        idle_in();
    endtask

    initial begin
        Rst_n = 0;
        idle_in();
        repeat (2) @(negedge Clk);
        check("rst_ovalid", 64'(OValid), 64'd0);
        check("rst_ostall", 64'(OStall), 64'd0);
        Rst_n = 1;

        drive(0, 0, 64'h1234, 64'h0, 5'd5, 2'b10);
        check("pass_stall_pre", 64'(OStall), 64'd0);
        step();
        idle_in();
        check("pass_valid", 64'(OValid), 64'd1);
        check("pass_alu", OAlu, 64'h1234);
        check("pass_rd", 64'(OInstruction), 64'd5);
        check("pass_wb", 64'(OWB), 64'd2);
        check("pass_dmem", ODataMemory, 64'd0);
        check("pass_stall", 64'(OStall), 64'd0);
        step();
        check("pass_valid_drop", 64'(OValid), 64'd0);
        check("pass_wb_drop", 64'(OWB), 64'd0);

        mem_op("st40", 0, 1, 64'h40, 64'hDEADBEEF_CAFEF00D, 5'd0, 2'b00);
        check("st40_valid", 64'(OValid), 64'd1);
        check("st40_dmem", ODataMemory, 64'd0);
        mem_op("ld40", 1, 0, 64'h40, 64'h0, 5'd7, 2'b01);
        check("ld40_valid", 64'(OValid), 64'd1);
        check("ld40_data", ODataMemory, 64'hDEADBEEF_CAFEF00D);
        check("ld40_rd", 64'(OInstruction), 64'd7);
        check("ld40_wb", 64'(OWB), 64'd1);
        check("ld40_alu", OAlu, 64'h40);
        check("ld40_mis", 64'(OMisaligned), 64'd0);

        mem_op("st08", 0, 1, 64'h8, 64'h1111_2222_3333_4444, 5'd0, 2'b00);
        mem_op("ldwrap", 1, 0, 64'h808, 64'h0, 5'd9, 2'b01);
        check("ldwrap_data", ODataMemory, 64'h1111_2222_3333_4444);

        mem_op("rmw", 1, 1, 64'h8, 64'hAAAA_0000_BBBB_0000, 5'd4, 2'b01);
        check("rmw_old_data", ODataMemory, 64'h1111_2222_3333_4444);
        mem_op("rmw_chk", 1, 0, 64'h8, 64'h0, 5'd4, 2'b01);
        check("rmw_new_data", ODataMemory, 64'hAAAA_0000_BBBB_0000);

        mem_op("ldmis", 1, 0, 64'h43, 64'h0, 5'd3, 2'b01);
        check("ldmis_valid", 64'(OValid), 64'd1);
        check("ldmis_flag", 64'(OMisaligned), 64'd1);
        check("ldmis_wb", 64'(OWB), 64'd0);
        check("ldmis_dmem", ODataMemory, 64'd0);
        step();
        check("ldmis_flag_clear", 64'(OMisaligned), 64'd0);
        check("ldmis_valid_clear", 64'(OValid), 64'd0);
        mem_op("stmis", 0, 1, 64'h41, 64'h0, 5'd0, 2'b00);
        check("stmis_flag", 64'(OMisaligned), 64'd1);
        mem_op("ld40b", 1, 0, 64'h40, 64'h0, 5'd7, 2'b01);
        check("ld40b_data", ODataMemory, 64'hDEADBEEF_CAFEF00D);

        drive(0, 1, 64'h40, 64'h5555_5555_5555_5555, 5'd0, 2'b00);
        step();
        check("flush_busy1", 64'(OStall), 64'd1);
        step();
        check("flush_busy2", 64'(OStall), 64'd1);
        IFlush = 1;
        step();
        idle_in();
        check("flush_valid", 64'(OValid), 64'd0);
        check("flush_stall", 64'(OStall), 64'd0);
        step();
        check("flush_valid2", 64'(OValid), 64'd0);
        mem_op("ldflush", 1, 0, 64'h40, 64'h0, 5'd2, 2'b01);
        check("ldflush_data", ODataMemory, 64'hDEADBEEF_CAFEF00D);

        drive(0, 1, 64'h8, 64'h9999_9999_9999_9999, 5'd6, 2'b01);
        step();
        check("arst_busy", 64'(OStall), 64'd1);
        #2 Rst_n = 0;
        #1;
        check("arst_stall", 64'(OStall), 64'd0);
        check("arst_valid", 64'(OValid), 64'd0);
        check("arst_alu", OAlu, 64'd0);
        check("arst_rd", 64'(OInstruction), 64'd0);
        check("arst_dmem", ODataMemory, 64'd0);
        check("arst_wb", 64'(OWB), 64'd0);
        idle_in();
        repeat (2) @(negedge Clk);
        Rst_n = 1;
        mem_op("ldarst", 1, 0, 64'h8, 64'h0, 5'd11, 2'b01);
        check("ldarst_data", ODataMemory, 64'hAAAA_0000_BBBB_0000);
        check("ldarst_rd", 64'(OInstruction), 64'd11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage of the 64-bit pipeline, between the EX/MEM register (upstream) and the MEM/WB register (downstream).
- Accepts one instruction per cycle from EX/MEM. Performs an optional 64-bit data-memory load or store against an internal word array with configurable access latency.
- Stalls upstream while an access is in flight. Presents write-back control, load data, ALU result and destination register to MEM/WB.

Parameters:
- DEPTH, 256, number of 64-bit words in the data array (power of two)
- ADDR_W, 8, log2(DEPTH); word index = IAlu[ADDR_W+2:3]
- LAT, 2, memory access latency in cycles (>=1)

Ports:
- Clk  input  1  rising-edge clock, sole clock
- Rst_n  input  1  asynchronous active-low reset
- IValid  input  1  upstream instruction valid
- IFlush  input  1  synchronous flush; kills in-flight/outgoing instruction
- IMemRead  input  1  load request
- IMemWrite  input  1  store request
- IWB  input  2  write-back control, passed through
- IAlu  input  64  ALU result; byte address for loads/stores
- IWriteData  input  64  store data
- IInstruction  input  5  destination register index
- OStall  output  1  high: upstream must hold all inputs stable
- OValid  output  1  outputs valid for MEM/WB this cycle
- OWB  output  2  write-back control (00 whenever OValid=0)
- ODataMemory  output  64  load data (0 for non-loads)
- OAlu  output  64  ALU result, passed through
- OInstruction  output  5  destination register, passed through
- OMisaligned  output  1  one-cycle pulse with OValid for misaligned load/store

Behaviour:
- Reset (Rst_n=0, asynchronous):
  - State IDLE, counter 0.
  - OValid=0, OStall=0, OWB=00, ODataMemory=0, OAlu=0, OInstruction=0, OMisaligned=0.
  - Data array not cleared.
  - Reset during BUSY aborts the access; a pending store is not written.
- States: IDLE, BUSY. OStall = (state==BUSY), decoded combinationally from state.
- IDLE, rising edge:
  - IFlush=1: OValid<=0, OWB<=00, nothing accepted.
  - IValid=0: OValid<=0, OWB<=00, OMisaligned<=0.
  - IValid=1, no memory op (IMemRead=IMemWrite=0): register IWB, IAlu, IInstruction; ODataMemory<=0; OValid<=1. Latency 1 edge. Stay IDLE.
  - IValid=1 with a memory op: capture all inputs internally; counter<=LAT-1; OValid<=0, OWB<=00; go BUSY.
  - IMemRead and IMemWrite both 1: the store takes priority, and ODataMemory returns the pre-write word (read-before-write).
- BUSY, rising edge:
  - IValid and inputs ignored (upstream holds them).
  - IFlush=1: abort, no write, OValid<=0, go IDLE.
  - Counter !=0: decrement.
  - Counter ==0, aligned (captured IAlu[2:0]==000):
    - Store: array[index]<=captured write data.
    - Load: ODataMemory<=array[index].
    - OAlu, OInstruction, OWB from captured values; OValid<=1; go IDLE.
  - Counter ==0, misaligned:
    - No write; ODataMemory<=0; OWB<=00 (write-back suppressed).
    - OMisaligned<=1, OValid<=1; go IDLE.
- Memory op timing:
  - Accepted at edge E0; result valid after edge E0+LAT.
  - OStall high for exactly LAT cycles.
  - The held upstream instruction is accepted at the first edge after OStall falls. Back-to-back memory ops therefore sustain one op per LAT+1 cycles.
- Addressing: bits above ADDR_W+2 are ignored, so addresses wrap modulo DEPTH words.
- Non-valid cycles: OAlu, OInstruction and ODataMemory hold their last values. OValid=0 and OWB=00 guarantee no register-file write.
- OMisaligned is valid only alongside OValid, and clears on the next edge.

Test Plan:
- Reset, then IValid=1, no mem op, IAlu=64'h1234, IInstruction=5, IWB=2'b10 -> next cycle OValid=1, OAlu=64'h1234, OInstruction=5, OWB=10, ODataMemory=0, OStall never 1.
- LAT=2: store IAlu=64'h40, IWriteData=64'hDEADBEEF_CAFEF00D, then load IAlu=64'h40, rd=7 -> each op: OStall high 2 cycles; load OValid with ODataMemory=64'hDEADBEEF_CAFEF00D, OInstruction=7.
- Store to 64'h8 then load from 64'h8 + DEPTH*8 -> load returns the stored word (wrap-around).
- Load at IAlu=64'h43 -> after LAT cycles OValid=1, OMisaligned=1, OWB=00, ODataMemory=0; no array change (verify with a later aligned load of 64'h40).
- Store issued, IFlush=1 in second BUSY cycle -> no OValid, state IDLE next cycle, later load of that address returns the old value.
- Rst_n pulsed low mid-BUSY (asynchronously, between edges) -> all outputs 0 immediately, OStall=0, store not performed; next instruction accepted normally.
